// File: rtl/sevenseg_scan.sv
// Eight-digit common-anode seven-segment scanner. Hex nibbles, decimal points and per-digit
// blanking are double-buffered so that new data is swapped in only at a frame boundary.
// Each digit slot opens with a dead-time gap (all anodes off) to prevent ghosting.
module sevenseg_scan #(
  parameter int unsigned CLK_FREQUENCY_HZ       = 100_000_000,
  parameter int unsigned REFRESH_FREQUENCY_HZ   = 2000,
  parameter int unsigned CNTR_WIDTH             = 32,
  parameter int unsigned DEADTIME_CYCLES        = 16,
  parameter int unsigned SIMULATE               = 0,
  parameter int unsigned SIMULATE_FREQUENCY_CNT = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] digit_data,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blank_in,
  input  logic        load,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [7:0]  an_n,
  output logic        frame_done
);

  localparam int unsigned TopCntInt = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT :
                                      (CLK_FREQUENCY_HZ / REFRESH_FREQUENCY_HZ) - 1;
  localparam logic [CNTR_WIDTH-1:0] TopCnt = CNTR_WIDTH'(TopCntInt);
  localparam int unsigned DtW = (DEADTIME_CYCLES < 1) ? 1 : $clog2(DEADTIME_CYCLES + 1);
  localparam logic [DtW-1:0] DtInit = DtW'(DEADTIME_CYCLES);

  logic [CNTR_WIDTH-1:0] prescaler_q, prescaler_d;
  logic [2:0]            idx_q, idx_d;
  logic [DtW-1:0]        dt_cnt_q, dt_cnt_d;
  logic                  pending_valid_q, pending_valid_d;
  logic [31:0]           pending_digits_q, pending_digits_d;
  logic [7:0]            pending_dp_q, pending_dp_d;
  logic [7:0]            pending_blank_q, pending_blank_d;
  logic [31:0]           active_digits_q, active_digits_d;
  logic [7:0]            active_dp_q, active_dp_d;
  logic [7:0]            active_blank_q, active_blank_d;
  logic [6:0]            seg_n_q, seg_n_d;
  logic                  dp_n_q, dp_n_d;
  logic [7:0]            an_n_q, an_n_d;
  logic                  frame_done_q, frame_done_d;

  logic                  tick;
  logic                  boundary;
  logic [3:0]            cur_nibble;

  // Prescaler, slot index, dead-time counter and frame boundary detection
  always_comb begin
    tick         = (prescaler_q == TopCnt);
    boundary     = tick && (idx_q == 3'd7);
    prescaler_d  = tick ? '0 : prescaler_q + CNTR_WIDTH'(1);
    idx_d        = tick ? idx_q + 3'd1 : idx_q;
    dt_cnt_d     = dt_cnt_q;
    if (tick) begin
      dt_cnt_d = DtInit;
    end else if (dt_cnt_q != '0) begin
      dt_cnt_d = dt_cnt_q - DtW'(1);
    end
    frame_done_d = boundary;
  end

  // Double buffering: a load always lands in pending; the old pending moves to active at the
  // boundary, so a load on the boundary cycle itself waits for the following frame.
  always_comb begin
    pending_digits_d = pending_digits_q;
    pending_dp_d     = pending_dp_q;
    pending_blank_d  = pending_blank_q;
    pending_valid_d  = pending_valid_q;
    active_digits_d  = active_digits_q;
    active_dp_d      = active_dp_q;
    active_blank_d   = active_blank_q;
    if (boundary && pending_valid_q) begin
      active_digits_d = pending_digits_q;
      active_dp_d     = pending_dp_q;
      active_blank_d  = pending_blank_q;
      pending_valid_d = 1'b0;
    end
    if (load) begin
      pending_digits_d = digit_data;
      pending_dp_d     = dp_in;
      pending_blank_d  = blank_in;
      pending_valid_d  = 1'b1;
    end
  end

  // Registered outputs computed from the next-state index and active data
  always_comb begin
    cur_nibble = active_digits_d[{idx_d, 2'b00} +: 4];
    unique case (cur_nibble)
      4'h0:    seg_n_d = 7'h40;
      4'h1:    seg_n_d = 7'h79;
      4'h2:    seg_n_d = 7'h24;
      4'h3:    seg_n_d = 7'h30;
      4'h4:    seg_n_d = 7'h19;
      4'h5:    seg_n_d = 7'h12;
      4'h6:    seg_n_d = 7'h02;
      4'h7:    seg_n_d = 7'h78;
      4'h8:    seg_n_d = 7'h00;
      4'h9:    seg_n_d = 7'h10;
      4'hA:    seg_n_d = 7'h08;
      4'hB:    seg_n_d = 7'h03;
      4'hC:    seg_n_d = 7'h46;
      4'hD:    seg_n_d = 7'h21;
      4'hE:    seg_n_d = 7'h06;
      default: seg_n_d = 7'h0E;
    endcase
    dp_n_d = ~active_dp_d[idx_d];
    // Blanking only suppresses the anode; cathodes keep tracking the data
    if ((dt_cnt_d != '0) || active_blank_d[idx_d]) begin
      an_n_d = 8'hFF;
    end else begin
      an_n_d = ~(8'h01 << idx_d);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q      <= '0;
      idx_q            <= 3'd0;
      dt_cnt_q         <= '0;
      pending_valid_q  <= 1'b0;
      pending_digits_q <= 32'h0;
      pending_dp_q     <= 8'h00;
      pending_blank_q  <= 8'hFF;
      active_digits_q  <= 32'h0;
      active_dp_q      <= 8'h00;
      active_blank_q   <= 8'hFF;
      seg_n_q          <= 7'h7F;
      dp_n_q           <= 1'b1;
      an_n_q           <= 8'hFF;
      frame_done_q     <= 1'b0;
    end else begin
      prescaler_q      <= prescaler_d;
      idx_q            <= idx_d;
      dt_cnt_q         <= dt_cnt_d;
      pending_valid_q  <= pending_valid_d;
      pending_digits_q <= pending_digits_d;
      pending_dp_q     <= pending_dp_d;
      pending_blank_q  <= pending_blank_d;
      active_digits_q  <= active_digits_d;
      active_dp_q      <= active_dp_d;
      active_blank_q   <= active_blank_d;
      seg_n_q          <= seg_n_d;
      dp_n_q           <= dp_n_d;
      an_n_q           <= an_n_d;
      frame_done_q     <= frame_done_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

endmodule
